// File: rtl/dekatron_step_controller_if.sv
// dekatron_step_controller_if: command handshake and status between the DPC sequencer and the step controller
interface dekatron_step_controller_if;
  logic       Req;
  logic       Ready;
  logic [1:0] Cmd;
  logic       Dir;
  logic [3:0] Arg;
  logic       Busy;
  logic       Done;
  logic       Error;
  logic [3:0] Position;
  modport master (output Req, Cmd, Dir, Arg, input Ready, Busy, Done, Error, Position);
  modport slave  (input Req, Cmd, Dir, Arg, output Ready, Busy, Done, Error, Position);
endinterface

// File: rtl/dekatron_step_controller.sv
// dekatron_step_controller: turns move commands into whole 3-cycle dekatron steps and tracks the tube position
module dekatron_step_controller #(
  parameter int DEK_CATHODES = 10,
  parameter int GAP_CYCLES   = 2,
  parameter int HOME_MAX     = 20
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Zero_n,
  dekatron_step_controller_if.slave bus,
  output logic Dek_En,
  output logic Dek_Reverse
);
  typedef enum logic [2:0] {IDLE, PLAN, STEP, GAP, DONE} state_t;
  localparam logic [1:0] C_STEP = 2'd0, C_GOTO = 2'd1, C_HOME = 2'd2;
  localparam logic [4:0] N = 5'(DEK_CATHODES);
  localparam logic [3:0] N_LAST = 4'(DEK_CATHODES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] HOME_LAST = 8'(HOME_MAX);
  state_t state, state_n;
  logic [1:0] cmd;
  logic [3:0] arg, pos, rem, plan_n, pos_next;
  logic [4:0] f, r;
  logic [7:0] cnt, taken;
  logic dir_l, error, zero_ff1, zero_sync;
  logic plan_rev, plan_err, step_end, gap_end, gap_more;
  always_comb begin
    f = ({1'b0, arg} >= {1'b0, pos}) ? {1'b0, arg} - {1'b0, pos} : {1'b0, arg} + N - {1'b0, pos};
    r = N - f;
    plan_err = (cmd == 2'd3) || (cmd == C_GOTO && {1'b0, arg} >= N);
    // Ties between forward and reverse distance go forward
    plan_n = plan_err ? 4'd0 :
             cmd == C_STEP ? arg :
             cmd == C_HOME ? {3'b0, zero_sync} :
             f <= r ? f[3:0] : r[3:0];
    plan_rev = cmd == C_STEP ? dir_l : (cmd == C_GOTO && f > r);
    step_end = state == STEP && cnt == 8'd2;
    gap_end = state == GAP && cnt == GAP_LAST;
    gap_more = cmd == C_HOME ? (zero_sync && taken != HOME_LAST) : rem != 4'd0;
    pos_next = Dek_Reverse ? (pos == 4'd0 ? N_LAST : pos - 4'd1) : (pos == N_LAST ? 4'd0 : pos + 4'd1);
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = bus.Req ? PLAN : IDLE;
      PLAN:    state_n = plan_n != 4'd0 ? STEP : DONE;
      STEP:    state_n = step_end ? GAP : STEP;
      GAP:     state_n = gap_end ? (gap_more ? STEP : DONE) : GAP;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      {cmd, arg, dir_l, rem, pos, cnt, taken, error, Dek_Reverse} <= '0;
      zero_ff1 <= 1'b1;
      zero_sync <= 1'b1;
    end else begin
      zero_ff1 <= Zero_n;
      zero_sync <= zero_ff1;
      cnt <= state_n != state ? 8'd0 : cnt + 8'd1;
      if (state == IDLE && bus.Req) begin
        cmd <= bus.Cmd;
        arg <= bus.Arg;
        dir_l <= bus.Dir;
        error <= 1'b0;
        taken <= '0;
      end
      if (state == PLAN) begin
        rem <= plan_n;
        Dek_Reverse <= plan_rev;
        error <= plan_err;
        if (cmd == C_HOME && !zero_sync) pos <= '0;
      end
      if (step_end) begin
        pos <= pos_next;
        rem <= rem - 4'd1;
        taken <= taken + 8'd1;
      end
      // HOME gives up after HOME_MAX steps but keeps the tracked position
      if (gap_end && cmd == C_HOME) begin
        if (!zero_sync) pos <= '0;
        else if (taken == HOME_LAST) error <= 1'b1;
      end
    end
  end
  assign Dek_En = state == STEP;
  assign bus.Ready = state == IDLE;
  assign bus.Busy = state != IDLE;
  assign bus.Done = state == DONE;
  assign bus.Error = error;
  assign bus.Position = pos;
endmodule

// File: tb/tb_dekatron_step_controller.sv
// tb_dekatron_step_controller: directed commands with a queued scoreboard checked on each Done
module tb_dekatron_step_controller;
  logic Clk = 0, Rst_n = 0, Dek_En, Dek_Reverse, Zero_n;
  dekatron_step_controller_if bus();
  dekatron_step_controller dut (.Clk(Clk), .Rst_n(Rst_n), .Zero_n(Zero_n), .bus(bus), .Dek_En(Dek_En), .Dek_Reverse(Dek_Reverse));
  always #5 Clk = ~Clk;
  typedef struct {int pos; int err; int lat; int en; int rev;} exp_t;
  exp_t q[$];
  int total = 0, passed = 0, done_cnt = 0;
  int lat = 0, en_cnt = 0, run = 0, shape_bad = 0;
  bit armed = 0;
  int ens = 0, ens_base = 0, glow_at = 0;
  // Tube model: cathode 0 glows once glow_at enabled pulses have been seen
  assign Zero_n = !(glow_at != 0 && ens - ens_base >= glow_at);
  always @(negedge Clk) if (Dek_En) ens++;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  always @(negedge Clk) begin
    exp_t e;
    if (armed) lat++;
    if (Dek_En) begin
      en_cnt++;
      run++;
      if (q.size() != 0 && int'(Dek_Reverse) != q[0].rev) shape_bad++;
    end else if (run != 0) begin
      if (run != 3) shape_bad++;
      run = 0;
    end
    if (bus.Done) begin
      done_cnt++;
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got Done with no pending command at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("position", int'(bus.Position), e.pos);
        chk("error", int'(bus.Error), e.err);
        chk("latency", lat, e.lat);
        chk("en_cycles", en_cnt, e.en);
        chk("step_shape_dir", shape_bad, 0);
        armed = 0;
      end
    end
    if (bus.Req && bus.Ready) begin
      armed = 1;
      lat = 0;
      en_cnt = 0;
      shape_bad = 0;
      run = 0;
    end
  end
  task automatic wait_done(input int start, input int limit);
    for (int i = 0; i < limit && done_cnt == start; i++) @(posedge Clk);
    if (done_cnt == start) begin
      total++;
      $display("FAIL timeout: got no Done expected Done within %0d cycles", limit);
    end
  endtask
  task automatic issue(input logic [1:0] c, input logic d, input logic [3:0] a);
    @(posedge Clk); #1;
    for (int i = 0; i < 50 && !bus.Ready; i++) begin @(posedge Clk); #1; end
    bus.Req = 1; bus.Cmd = c; bus.Dir = d; bus.Arg = a;
  endtask
  task automatic send(input logic [1:0] c, input logic d, input logic [3:0] a,
                      input int pos, input int err, input int n, input int rev);
    int start;
    start = done_cnt;
    issue(c, d, a);
    q.push_back('{pos, err, 2 + n * 5, 3 * n, rev});
    @(posedge Clk); #1 bus.Req = 0;
    wait_done(start, 200);
  endtask
  initial begin
    int start, k;
    bus.Req = 0; bus.Cmd = 0; bus.Dir = 0; bus.Arg = 0;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1;
    @(negedge Clk);
    chk("rst_ready", bus.Ready, 1); chk("rst_busy", bus.Busy, 0); chk("rst_done", bus.Done, 0);
    chk("rst_error", bus.Error, 0); chk("rst_pos", bus.Position, 0); chk("rst_en", Dek_En, 0);
    chk("rst_rev", Dek_Reverse, 0);
    send(0, 0, 3, 3, 0, 3, 0);
    send(1, 0, 1, 1, 0, 2, 1);
    send(1, 0, 8, 8, 0, 3, 1);
    send(1, 0, 2, 2, 0, 4, 0);
    send(1, 0, 7, 7, 0, 5, 0);
    send(1, 0, 7, 7, 0, 0, 0);
    send(1, 0, 12, 7, 1, 0, 0);
    @(posedge Clk); #1 ens_base = ens; glow_at = 9;
    send(2, 0, 0, 0, 0, 3, 0);
    send(2, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1 glow_at = 0;
    repeat (3) @(posedge Clk);
    send(0, 0, 4, 4, 0, 4, 0);
    send(2, 0, 0, 4, 1, 20, 0);
    repeat (3) @(posedge Clk);
    #1 chk("error_held", bus.Error, 1);
    issue(0, 0, 2);
    @(posedge Clk); #1 bus.Req = 0;
    k = 0;
    for (int i = 0; i < 20 && k < 2; i++) begin @(negedge Clk); if (Dek_En) k++; end
    chk("reached_2nd_en", k, 2);
    #2 Rst_n = 0;
    #1 chk("async_en_drop", Dek_En, 0); chk("reset_pos", bus.Position, 0);
    @(posedge Clk); #1 Rst_n = 1;
    @(negedge Clk); chk("ready_after_rst", bus.Ready, 1); chk("en_after_rst", Dek_En, 0);
    start = done_cnt;
    issue(0, 0, 2);
    q.push_back('{2, 0, 12, 6, 0});
    q.push_back('{2, 1, 2, 0, 0});
    @(posedge Clk); #1 bus.Cmd = 3; bus.Arg = 5; bus.Dir = 1;
    wait_done(start, 100);
    #1 @(posedge Clk); #1 bus.Req = 0;
    wait_done(start + 1, 50);
    send(0, 0, 0, 2, 0, 0, 0);
    send(0, 1, 1, 1, 0, 1, 1);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
